// File: rtl/sv_uart_tx.sv
// AXI-Stream UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit period comes from idivider (clamped to 2); it is latched with each word.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | line at mark, waiting for a word
// S_START | driving the start bit (0)
// S_DATA  | shifting data bits out LSB first
// S_PAR   | driving the parity bit
// S_STOP  | driving stop bit(s); can accept the next word on the last cycle
module sv_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [15:0]           idivider,
    output logic                  otx,
    output logic                  obusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           last_q, last_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  otx_q, otx_d;
    logic [15:0]           div_last;
    logic                  strobe;
    logic                  final_stop;
    logic                  accept;

    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
        logic x;
        x = ^w;
        return (PARITY == 1) ? ~x : x;
    endfunction

    // last_q holds P-1 so the strobe is a plain equality compare
    assign div_last      = (idivider < 16'd2) ? 16'd1 : idivider - 16'd1;
    assign strobe        = (cnt_q == last_q);
    assign final_stop    = (state_q == S_STOP) && strobe && (bit_q == 4'(STOP_BITS - 1));
    assign s_axis_tready = ~irst & ((state_q == S_IDLE) | final_stop);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = strobe ? 16'd0 : cnt_q + 16'd1;
        last_d  = last_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        otx_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
            end
            S_START: begin
                if (strobe) begin
                    state_d = S_DATA;
                    bit_d   = 4'd0;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_WIDTH - 1)) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (strobe) begin
                    state_d = S_STOP;
                    bit_d   = 4'd0;
                end
            end
            S_STOP: begin
                if (final_stop) begin
                    state_d = S_IDLE;
                    bit_d   = 4'd0;
                end else if (strobe) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accept on the final stop cycle chains straight into the next start bit
        if (accept) begin
            state_d = S_START;
            cnt_d   = 16'd0;
            bit_d   = 4'd0;
            shift_d = s_axis_tdata;
            par_d   = word_parity(s_axis_tdata);
            last_d  = div_last;
        end

        case (state_d)
            S_START: otx_d = 1'b0;
            S_DATA:  otx_d = shift_d[0];
            S_PAR:   otx_d = par_d;
            default: otx_d = 1'b1;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            last_q  <= 16'd1;
            bit_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            otx_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            otx_q   <= otx_d;
        end
    end

    assign otx   = otx_q;
    assign obusy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sv_uart_tx.sv
// Bench for sv_uart_tx: three parameter variants checked cycle by cycle against a
// frame-level line model, plus directed timing checks and a mid-bit sampling receiver.
module tb_sv_uart_tx;

    localparam int PM [3] = '{0, 2, 1};
    localparam int ST [3] = '{1, 1, 2};
    localparam int RX_DIV = 16;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [15:0] idivider = 16'd16;
    logic [7:0]  tdata_v  [3];
    logic        tvalid_v [3];
    logic        tready_v [3];
    logic        otx_v    [3];
    logic        busy_v   [3];

    int n_checks = 0;
    int n_fail   = 0;

    bit          exp_q [3][$];
    logic        cur_otx  [3];
    logic        cur_busy [3];
    bit          acc_flag [3];
    bit          chk_en = 1'b0;
    bit          rx_en  = 1'b0;
    logic [7:0]  lb_q [$];
    int          rx_cnt = 0;
    logic [7:0]  rx_w;

    int run [3], rb [3], last_run [3], last_rb [3], done_cnt [3];

    always #5 iclk = ~iclk;

    sv_uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_tx0 (
        .iclk(iclk), .irst(irst), .s_axis_tdata(tdata_v[0]), .s_axis_tvalid(tvalid_v[0]),
        .s_axis_tready(tready_v[0]), .idivider(idivider), .otx(otx_v[0]), .obusy(busy_v[0]));

    sv_uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_tx1 (
        .iclk(iclk), .irst(irst), .s_axis_tdata(tdata_v[1]), .s_axis_tvalid(tvalid_v[1]),
        .s_axis_tready(tready_v[1]), .idivider(idivider), .otx(otx_v[1]), .obusy(busy_v[1]));

    sv_uart_tx #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(2)) u_tx2 (
        .iclk(iclk), .irst(irst), .s_axis_tdata(tdata_v[2]), .s_axis_tvalid(tvalid_v[2]),
        .s_axis_tready(tready_v[2]), .idivider(idivider), .otx(otx_v[2]), .obusy(busy_v[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line levels for one frame, one queue entry per clock cycle
    task automatic push_frame(input int i, input logic [7:0] w, input int p);
        bit lv [$];
        lv.push_back(1'b0);
        for (int b = 0; b < 8; b++) lv.push_back(w[b]);
        if (PM[i] != 0) lv.push_back((^w) ^ (PM[i] == 1));
        for (int s = 0; s < ST[i]; s++) lv.push_back(1'b1);
        foreach (lv[k]) repeat (p) exp_q[i].push_back(lv[k]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cur_otx[i] = 1'b1; cur_busy[i] = 1'b0; acc_flag[i] = 1'b0;
            tvalid_v[i] = 1'b0; tdata_v[i] = 8'h00;
            run[i] = 0; rb[i] = 0; last_run[i] = 0; last_rb[i] = 0; done_cnt[i] = 0;
        end
    end

    always @(posedge iclk) begin
        for (int i = 0; i < 3; i++) begin
            acc_flag[i] = 1'b0;
            if (irst) begin
                exp_q[i].delete();
                cur_otx[i]  = 1'b1;
                cur_busy[i] = 1'b0;
            end else begin
                if (tvalid_v[i] && exp_q[i].size() == 0) begin
                    acc_flag[i] = 1'b1;
                    push_frame(i, tdata_v[i], (idivider < 16'd2) ? 2 : int'(idivider));
                    if (i == 0 && rx_en) lb_q.push_back(tdata_v[i]);
                end
                if (exp_q[i].size() > 0) begin
                    cur_otx[i]  = exp_q[i].pop_front();
                    cur_busy[i] = 1'b1;
                end else begin
                    cur_otx[i]  = 1'b1;
                    cur_busy[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge iclk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("otx%0d", i), otx_v[i], cur_otx[i]);
                check_val($sformatf("busy%0d", i), busy_v[i], cur_busy[i]);
                check_val($sformatf("ready%0d", i), tready_v[i], !irst && exp_q[i].size() == 0);
            end
        end
    end

    // Length of each busy run and how many of its cycles had tready high
    always @(negedge iclk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_v[i] === 1'b1) begin
                run[i]++;
                if (tready_v[i] === 1'b1) rb[i]++;
            end else if (run[i] > 0) begin
                last_run[i] = run[i];
                last_rb[i]  = rb[i];
                run[i] = 0;
                rb[i]  = 0;
                done_cnt[i]++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iclk);
            if (rx_en && otx_v[0] === 1'b0) begin
                repeat (RX_DIV / 2 - 1) @(negedge iclk);
                check_val("rx_start", otx_v[0], 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (RX_DIV) @(negedge iclk);
                    rx_w[b] = otx_v[0];
                end
                repeat (RX_DIV) @(negedge iclk);
                check_val("rx_stop", otx_v[0], 1'b1);
                check_val("rx_queue", lb_q.size() > 0, 1'b1);
                if (lb_q.size() > 0) check_val("rx_word", rx_w, lb_q.pop_front());
                rx_cnt++;
            end
        end
    end

    task automatic wait_acc(input int i);
        int n = 0;
        do begin
            @(posedge iclk); #1;
            n++;
        end while (!acc_flag[i] && n < 2000);
        if (!acc_flag[i]) check_val("acc_timeout", 32'(n), 32'd0);
    endtask

    task automatic send(input int i, input logic [7:0] w);
        tvalid_v[i] = 1'b1;
        tdata_v[i]  = w;
        wait_acc(i);
        tvalid_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int d0 = done_cnt[i];
        int n  = 0;
        while (done_cnt[i] == d0 && n < 5000) begin
            @(posedge iclk); #1;
            n++;
        end
        if (done_cnt[i] == d0) check_val("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy_v[i] !== 1'b0 && n < 5000) begin
            @(posedge iclk); #1;
            n++;
        end
        check_val("idle", busy_v[i], 1'b0);
    endtask

    // Random words with random tvalid gaps; tdata changes freely while not accepted
    task automatic stream(input int i, input int n, input bit rand_div);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 400 + 1000) begin
            if (rand_div) idivider = 16'($urandom_range(0, 12));
            tvalid_v[i] = ($urandom_range(0, 3) != 0);
            tdata_v[i]  = 8'($urandom);
            @(posedge iclk); #1;
            cyc++;
            if (acc_flag[i]) got++;
        end
        tvalid_v[i] = 1'b0;
        check_val("stream_words", 32'(got), 32'(n));
    endtask

    initial begin
        @(posedge iclk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        @(negedge iclk);
        check_val("rst_otx", otx_v[0], 1'b1);
        check_val("rst_busy", busy_v[0], 1'b0);
        check_val("rst_ready", tready_v[0], 1'b0);
        @(posedge iclk); #1;
        irst = 1'b0;
        @(negedge iclk);
        check_val("rel_ready", tready_v[0], 1'b1);
        @(posedge iclk); #1;

        idivider = 16'd16;
        send(0, 8'hA5);
        @(negedge iclk);
        check_val("basic_start", otx_v[0], 1'b0);
        wait_done(0);
        check_val("basic_len", 32'(last_run[0]), 32'd160);

        idivider = 16'd4;
        tvalid_v[0] = 1'b1;
        tdata_v[0]  = 8'h00;
        wait_acc(0);
        tdata_v[0]  = 8'hFF;
        wait_acc(0);
        tdata_v[0]  = 8'h3C;
        wait_acc(0);
        tvalid_v[0] = 1'b0;
        wait_done(0);
        check_val("b2b_len", 32'(last_run[0]), 32'd120);
        check_val("b2b_ready", 32'(last_rb[0]), 32'd3);

        idivider = 16'd8;
        send(1, 8'h01);
        repeat (77) @(negedge iclk);
        check_val("even_par", otx_v[1], 1'b1);
        wait_done(1);
        check_val("even_len", 32'(last_run[1]), 32'd88);

        send(2, 8'h01);
        repeat (77) @(negedge iclk);
        check_val("odd_par", otx_v[2], 1'b0);
        repeat (19) @(negedge iclk);
        check_val("stop2_otx", otx_v[2], 1'b1);
        check_val("stop2_busy", busy_v[2], 1'b1);
        wait_done(2);
        check_val("odd_len", 32'(last_run[2]), 32'd96);

        idivider = 16'd0;
        send(0, 8'h5C);
        wait_done(0);
        check_val("div0_len", 32'(last_run[0]), 32'd20);
        idivider = 16'd1;
        send(0, 8'hC5);
        wait_done(0);
        check_val("div1_len", 32'(last_run[0]), 32'd20);

        idivider = 16'd16;
        send(0, 8'h33);
        repeat (30) @(posedge iclk);
        #1;
        idivider = 16'd32;
        wait_done(0);
        check_val("divchg_old", 32'(last_run[0]), 32'd160);
        send(0, 8'hC3);
        wait_done(0);
        check_val("divchg_new", 32'(last_run[0]), 32'd320);

        idivider = 16'd16;
        send(0, 8'hA5);
        repeat (69) @(posedge iclk);
        #1;
        irst = 1'b1;
        @(posedge iclk); #1;
        irst = 1'b0;
        @(negedge iclk);
        check_val("abort_otx", otx_v[0], 1'b1);
        check_val("abort_busy", busy_v[0], 1'b0);
        check_val("abort_ready", tready_v[0], 1'b1);
        @(posedge iclk); #1;
        send(0, 8'h5A);
        wait_done(0);
        check_val("post_rst_len", 32'(last_run[0]), 32'd160);

        stream(1, 30, 1'b1);
        wait_idle(1);
        stream(2, 30, 1'b1);
        wait_idle(2);

        idivider = 16'(RX_DIV);
        @(posedge iclk); #1;
        rx_en = 1'b1;
        stream(0, 256, 1'b0);
        wait_idle(0);
        repeat (20) @(posedge iclk);
        #1;
        rx_en = 1'b0;
        check_val("rx_count", 32'(rx_cnt), 32'd256);
        check_val("rx_left", 32'(lb_q.size()), 32'd0);

        repeat (5) @(posedge iclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
